// File: rtl/instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// instr_mem_fetch
//
// Byte-addressed instruction memory with a program-load port and a single
// fetch port. After reset the memory is cleared one word per cycle; once the
// clear finishes, init_done rises and fetches/loads are serviced.
//
// Storage is word-organised and big-endian: byte address 4*w+0 lives in
// bits [31:24] of word w, byte 4*w+3 in bits [7:0].
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-low
//   pc           in   [ADDR_W] byte fetch address
//   fetch_req    in   fetch request this cycle
//   fetch_ready  out  fetch accepted when fetch_req && fetch_ready
//   stall        in   downstream hold: fetch outputs frozen
//   instr        out  [32] fetched instruction (0 on fault)
//   instr_valid  out  instr holds the result of an accepted fetch
//   fault        out  accepted fetch was misaligned or out of range
//   load_we      in   program-load write strobe (wins over fetch)
//   load_addr    in   [ADDR_W] byte address of load word, bits [1:0] ignored
//   load_data    in   [32] load word, big-endian
//   load_be      in   [4] byte enables, load_be[3] -> byte address+0
//   init_done    out  memory clear complete
// -----------------------------------------------------------------------------
module instr_mem_fetch #(
   parameter int DEPTH_BYTES = 64,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   input  logic              fetch_req,
   output logic              fetch_ready,
   input  logic              stall,
   output logic [31:0]       instr,
   output logic              instr_valid,
   output logic              fault,
   input  logic              load_we,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data,
   input  logic [3:0]        load_be,
   output logic              init_done
);

   localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
   localparam int WORD_AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   localparam logic [WORD_AW-1:0] LAST_WORD = WORD_AW'(DEPTH_WORDS - 1);
   // One extra bit so range checks near the top of the address space
   // cannot wrap back into the valid range.
   localparam logic [ADDR_W:0]    DEPTH_EXT = (ADDR_W + 1)'(DEPTH_BYTES);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [WORD_AW-1:0] clr_cnt;
   logic [31:0]        mem [DEPTH_WORDS];

   logic               clear_we;
   logic               load_en;
   logic               load_in_range;
   logic               fetch_acc;
   logic               fetch_bad;
   logic [ADDR_W:0]    pc_last;
   logic [WORD_AW-1:0] pc_word;
   logic [WORD_AW-1:0] load_word;
   logic [31:0]        rd_word;

   // --------------------------------------------------------------------------
   // Address decode
   // --------------------------------------------------------------------------
   assign pc_last       = {1'b0, pc} + (ADDR_W + 1)'(3);
   assign fetch_bad     = (pc[1:0] != 2'b00) || (pc_last >= DEPTH_EXT);
   assign pc_word       = pc[WORD_AW+1:2];

   // Byte address below capacity <=> word index in range, because the
   // capacity is a whole number of words.
   assign load_in_range = ({1'b0, load_addr} < DEPTH_EXT);
   assign load_word     = load_addr[WORD_AW+1:2];

   // Out-of-range pc values never use rd_word; the mux below discards it.
   assign rd_word       = mem[pc_word];

   assign fetch_acc     = fetch_req && fetch_ready;

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (clr_cnt == LAST_WORD) state_nxt = ST_READY;
         ST_READY: state_nxt = ST_READY;
         default:  state_nxt = ST_CLEAR;
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: outputs
   // --------------------------------------------------------------------------
   // NOTE: every output of this block gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      fetch_ready = 1'b0;
      init_done   = 1'b0;
      clear_we    = 1'b0;
      load_en     = 1'b0;
      case (state)
         ST_CLEAR: begin
            clear_we = 1'b1;
         end
         ST_READY: begin
            init_done   = 1'b1;
            // A load in the same cycle blocks the fetch: the load wins.
            fetch_ready = !stall && !load_we;
            load_en     = load_we && load_in_range;
         end
         default: ;
      endcase
   end

   // --------------------------------------------------------------------------
   // Clear word counter
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= (clr_cnt == LAST_WORD) ? '0 : clr_cnt + WORD_AW'(1);
      end
   end

   // --------------------------------------------------------------------------
   // Memory array
   // --------------------------------------------------------------------------
   // NOTE: the array has no reset branch; it maps onto plain RAM, and its
   // contents are defined by the clear sweep that follows every reset.
   always_ff @(posedge clk) begin
      if (clear_we) begin
         mem[clr_cnt] <= '0;
      end else if (load_en) begin
         for (int b = 0; b < 4; b++) begin
            if (load_be[b]) begin
               mem[load_word][b*8 +: 8] <= load_data[b*8 +: 8];
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Fetch output register
   // --------------------------------------------------------------------------
   // Stall freezes everything. Otherwise an accepted fetch loads a result,
   // and an idle cycle drops valid/fault while keeping the last instr.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr       <= '0;
         instr_valid <= 1'b0;
         fault       <= 1'b0;
      end else if (!stall) begin
         if (fetch_acc) begin
            instr       <= fetch_bad ? 32'h0 : rd_word;
            instr_valid <= 1'b1;
            fault       <= fetch_bad;
         end else begin
            instr_valid <= 1'b0;
            fault       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_fetch
//
// Self-checking bench for instr_mem_fetch. A byte-array reference model is
// updated on every load; each fetch pushes its expected result to a queue,
// and a monitor pops and compares when the DUT presents the fetch result.
// -----------------------------------------------------------------------------
module tb_instr_mem_fetch;

   localparam int DEPTH_BYTES = 64;
   localparam int ADDR_W      = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] pc;
   logic              fetch_req;
   logic              fetch_ready;
   logic              stall;
   logic [31:0]       instr;
   logic              instr_valid;
   logic              fault;
   logic              load_we;
   logic [ADDR_W-1:0] load_addr;
   logic [31:0]       load_data;
   logic [3:0]        load_be;
   logic              init_done;

   instr_mem_fetch #(
      .DEPTH_BYTES(DEPTH_BYTES),
      .ADDR_W     (ADDR_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .fetch_req  (fetch_req),
      .fetch_ready(fetch_ready),
      .stall      (stall),
      .instr      (instr),
      .instr_valid(instr_valid),
      .fault      (fault),
      .load_we    (load_we),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .load_be    (load_be),
      .init_done  (init_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] model [DEPTH_BYTES];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic       acc_q   = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference fetch: big-endian word, zero + fault on misalignment or
   // any part of the word beyond capacity (no address wrap).
   function automatic exp_t model_fetch(input logic [31:0] a);
      exp_t        e;
      logic [32:0] last;
      last = {1'b0, a} + 33'd3;
      if (a[1:0] != 2'b00 || last >= 33'(DEPTH_BYTES)) begin
         e.instr = 32'h0;
         e.fault = 1'b1;
      end else begin
         e.instr = {model[a], model[a+1], model[a+2], model[a+3]};
         e.fault = 1'b0;
      end
      return e;
   endfunction

   // Acceptance is sampled at the edge; the result is compared half a
   // cycle later, away from the edge.
   always @(posedge clk) acc_q <= reset && fetch_req && fetch_ready;

   always @(negedge clk) begin
      if (acc_q) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_fetch", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("fetch_instr", instr, e.instr);
            check("fetch_valid", 32'(instr_valid), 32'd1);
            check("fetch_fault", 32'(fault), 32'(e.fault));
         end
      end
   end

   // All tasks start and end on a falling edge.
   task automatic do_fetch(input logic [31:0] a);
      pc        = a;
      fetch_req = 1'b1;
      #1;
      check("fetch_ready", 32'(fetch_ready), 32'd1);
      exp_q.push_back(model_fetch(a));
      @(negedge clk);
      fetch_req = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic with_fetch);
      load_we   = 1'b1;
      load_addr = a;
      load_data = d;
      load_be   = be;
      fetch_req = with_fetch;
      pc        = 32'h0;
      #1;
      check("load_blocks_fetch", 32'(fetch_ready), 32'd0);
      if (a < 32'(DEPTH_BYTES)) begin
         for (int b = 0; b < 4; b++) begin
            if (be[3-b]) model[{a[31:2], 2'b00} + b] = d[31-8*b -: 8];
         end
      end
      @(negedge clk);
      load_we   = 1'b0;
      fetch_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_instr"},       instr,              32'h0);
      check({tag, "_valid"},       32'(instr_valid),   32'd0);
      check({tag, "_fault"},       32'(fault),         32'd0);
      check({tag, "_init_done"},   32'(init_done),     32'd0);
      check({tag, "_fetch_ready"}, 32'(fetch_ready),   32'd0);
   endtask

   // Counts rising edges from reset release until init_done is seen.
   task automatic wait_init(output int n);
      n = 0;
      while (!init_done && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(negedge clk);
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH_BYTES; i++) model[i] = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      exp_t held;

      reset     = 1'b0;
      pc        = '0;
      fetch_req = 1'b0;
      stall     = 1'b0;
      load_we   = 1'b0;
      load_addr = '0;
      load_data = '0;
      load_be   = '0;
      model_clear();

      // Reset state and clear duration
      repeat (2) @(negedge clk);
      check_reset_outputs("rst0");
      reset = 1'b1;
      wait_init(n);
      check("init_cycles", 32'(n), 32'd16);

      // Cleared memory reads zero
      do_fetch(32'h0);
      do_fetch(32'h3C);

      // Full-word load then fetch
      do_load(32'h0, 32'hFC221821, 4'hF, 1'b0);
      do_fetch(32'h0);

      // Partial byte-enable merge
      do_load(32'h4, 32'h1C210002, 4'hF, 1'b0);
      do_load(32'h4, 32'hAA000000, 4'h8, 1'b0);
      do_fetch(32'h4);

      // Low-order address bits ignored; be[0] -> byte address+3
      do_load(32'h3B, 32'h12345678, 4'h5, 1'b0);
      do_fetch(32'h38);

      // Last in-range word, dropped out-of-range load
      do_load(32'h3C, 32'hCAFEF00D, 4'hF, 1'b0);
      do_load(32'h40, 32'hDEADBEEF, 4'hF, 1'b0);
      do_fetch(32'h3C);
      do_fetch(32'h0);

      // Faulting fetches
      do_fetch(32'h6);
      do_fetch(32'h40);
      do_fetch(32'h3D);
      do_fetch(32'hFFFFFFFE);
      do_fetch(32'hFFFFFFFC);

      // Stall holds the last result and blocks new fetches
      do_fetch(32'h4);
      held      = model_fetch(32'h4);
      stall     = 1'b1;
      fetch_req = 1'b1;
      pc        = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_instr",       instr,            held.instr);
         check("stall_valid",       32'(instr_valid), 32'd1);
         check("stall_fault",       32'(fault),       32'd0);
         check("stall_fetch_ready", 32'(fetch_ready), 32'd0);
      end
      fetch_req = 1'b0;
      stall     = 1'b0;
      @(negedge clk);
      check("idle_valid", 32'(instr_valid), 32'd0);
      check("idle_fault", 32'(fault),       32'd0);
      check("idle_instr", instr,            held.instr);

      // Load and fetch together: load wins, then the write is visible
      do_load(32'h8, 32'h0BADF00D, 4'hF, 1'b1);
      do_fetch(32'h8);

      // Mixed random traffic
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(1, 0) == 1) begin
            do_load(32'($urandom_range(71, 0)), $urandom, 4'($urandom_range(15, 0)), 1'b0);
         end else begin
            do_fetch(32'($urandom_range(70, 0)));
         end
      end

      // Reset with non-zero instr: outputs drop without a clock edge
      do_fetch(32'h0);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("rst1");
      model_clear();
      @(negedge clk);
      reset = 1'b1;

      // Abort the clear at counter 5 and restart it
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_mid_clear");
      @(negedge clk);
      reset = 1'b1;
      wait_init(n);
      check("init_cycles_restart", 32'(n), 32'd16);
      do_fetch(32'h0);
      do_fetch(32'h4);
      do_fetch(32'h3C);

      @(negedge clk);
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_mem_fetch.md
INSTR_MEM_FETCH -- requirements
Module: instr_mem_fetch

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 64: byte capacity; must be a multiple of 4.
REQ-002 SHALL have parameter ADDR_W, default 32: width of pc and load_addr.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low (0 = reset).
REQ-005 SHALL have port pc, input, ADDR_W: byte fetch address, big-endian word.
REQ-006 SHALL have port fetch_req, input, 1: fetch request this cycle.
REQ-007 SHALL have port fetch_ready, output, 1: fetch accepted when fetch_req and fetch_ready are both 1.
REQ-008 SHALL have port stall, input, 1: pipeline hold from downstream.
REQ-009 SHALL have port instr, output, 32: fetched instruction code.
REQ-010 SHALL have port instr_valid, output, 1: instr holds the result of an accepted fetch.
REQ-011 SHALL have port fault, output, 1: the accepted fetch was misaligned or out of range.
REQ-012 SHALL have port load_we, input, 1: program-load write strobe.
REQ-013 SHALL have port load_addr, input, ADDR_W: byte address of the load word; bits [1:0] are ignored.
REQ-014 SHALL have port load_data, input, 32: load word, big-endian.
REQ-015 SHALL have port load_be, input, 4: byte enables; load_be[3] selects load_data[31:24], written to byte address+0.
REQ-016 SHALL have port init_done, output, 1: memory clear complete, block operational.

Function
REQ-017 SHALL implement a two-state FSM, CLEAR and READY; reset forces CLEAR.
REQ-018 In CLEAR, the block SHALL zero one 32-bit word per cycle, using a word counter from 0 to DEPTH_BYTES/4-1.
REQ-019 In CLEAR, the block SHALL move to READY on the cycle after the last word is written, and init_done SHALL be 1 from that cycle on.
REQ-020 In CLEAR, fetch_ready SHALL be 0 and load_we SHALL be ignored.
REQ-021 fetch_ready SHALL equal (state==READY) && !stall && !load_we.
REQ-022 A load write in READY SHALL update only the bytes whose load_be bit is 1, at word floor(load_addr/4); the write is visible to a fetch accepted on the next cycle.
REQ-023 A load write to an out-of-range word SHALL be dropped with no side effects.
REQ-024 An accepted fetch SHALL have 1-cycle latency: on the next edge instr = {M[pc],M[pc+1],M[pc+2],M[pc+3]}, instr_valid = 1, and fault = 0.
REQ-025 A fetch with pc[1:0]!=0, or with pc+3 >= DEPTH_BYTES, SHALL be accepted, and on the next edge instr = 0, instr_valid = 1, and fault = 1.
REQ-026 The range check SHALL use the full ADDR_W width with no wrap-around; pc near 2^ADDR_W-1 is a fault.
REQ-027 While stall=1, instr, instr_valid and fault SHALL hold their values.
REQ-028 With stall=0 and no accepted fetch, instr_valid and fault SHALL go to 0 on the next edge and instr SHALL hold.
REQ-029 When load_we and fetch_req are both 1 in the same cycle, the load SHALL win and the fetch SHALL NOT be accepted.

Reset
REQ-030 On reset low, the block SHALL immediately set instr = 0, instr_valid = 0, fault = 0, init_done = 0, fetch_ready = 0, state = CLEAR, and counter = 0, independent of clk.
REQ-031 Reset asserted mid-CLEAR or mid-fetch SHALL abort the operation; after release the block SHALL restart the full clear, and all prior memory contents are lost.

Verification
REQ-032 The bench SHALL check: release reset with DEPTH_BYTES=64 -> init_done rises exactly 16 cycles later; a fetch at pc=0 returns 0x00000000.
REQ-033 The bench SHALL check: load 0xFC221821 at addr 0 with be=0xF, then fetch pc=0 -> instr=0xFC221821, valid=1, fault=0 one cycle after acceptance.
REQ-034 The bench SHALL check: load 0x1C210002 at addr 4 with be=0xF, then load 0xAA000000 at addr 4 with be=0x8, then fetch pc=4 -> instr=0xAA210002.
REQ-035 The bench SHALL check: fetch pc=6, and fetch pc=64 -> each gives instr=0, fault=1, valid=1; fetch pc=0xFFFFFFFE -> fault=1.
REQ-036 The bench SHALL check: stall=1 for 3 cycles after a valid fetch -> instr, instr_valid and fault held and fetch_ready=0; with load_we and fetch_req both 1 -> fetch_ready=0 and the write lands.
REQ-037 The bench SHALL check: assert reset during CLEAR at counter 5, then release -> init_done again rises 16 cycles after release, and all outputs are 0 during reset.
